// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its helpers.
// The FIFO and the arbiter both default their word width from here.
package fifo_wr_arbiter_pkg;

  // Arbiter FSM encoding
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Common defaults; WIDTH must match the FIFO data width
  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_NUM_REQ   = 4;
  localparam int DEFAULT_MAX_BURST = 4;

  // (base + off) modulo n, valid for base < n and off <= n
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: searches req starting just after last_idx, wrapping
// around, and returns the first requesting index. Purely combinational.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  // Candidate gi is the (gi+1)-th index after last_idx, so candidate 0 has
  // the highest priority and last_idx itself (candidate NUM_REQ-1) the lowest.
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'(wrap_add(int'(last_idx), gi + 1, NUM_REQ));
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Priority encode over the rotated candidates; lowest candidate wins
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        pick_idx   = cand_idx[k];
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-based round-robin arbiter sharing one FIFO write port between
// NUM_REQ producers. A grant lasts up to MAX_BURST accepted words or until
// the producer drops req; every grant is followed by one IDLE cycle.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEFAULT_NUM_REQ,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     fifo_full,
  output logic                     fifo_we,
  output logic [WIDTH-1:0]         fifo_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]   last_idx_reg, last_idx_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;

  logic [WIDTH-1:0]   req_words [NUM_REQ];
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               word_ok;
  logic               burst_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_words[gi]   = req_data[gi*WIDTH +: WIDTH];
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
      // grant_reg is one-hot in GRANT, so only the owner can see an ack
      assign ack[gi]         = fifo_we & grant_reg[gi];
    end
  endgenerate

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_idx   (last_idx_reg),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // While granted, last_idx_reg is the owner's index. fifo_full is used
  // unregistered, so a word is only taken when the FIFO can accept it now.
  assign word_ok    = (state_reg == ST_GRANT) & req[last_idx_reg] & ~fifo_full;
  assign burst_last = (burst_cnt_reg == CNT_W'(MAX_BURST - 1));

  // State register; async reset aborts any burst and parks priority so that
  // producer 0 is searched first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      last_idx_reg  <= IDX_W'(NUM_REQ - 1);
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      last_idx_reg  <= last_idx_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Next-state: arbitrate in IDLE, count words and decide release in GRANT
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    last_idx_next  = last_idx_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next     = ST_GRANT;
          grant_next     = pick_onehot;
          last_idx_next  = pick_idx;
          burst_cnt_next = '0;
        end
      end
      ST_GRANT: begin
        if (word_ok) begin
          burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        end
        // Release on a full burst or when the owner stops requesting; a
        // stall on fifo_full alone keeps the grant.
        if ((word_ok && burst_last) || !req[last_idx_reg]) begin
          state_next     = ST_IDLE;
          grant_next     = '0;
          burst_cnt_next = '0;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        grant_next     = '0;
        burst_cnt_next = '0;
      end
    endcase
  end

  // Outputs: write port driven only in GRANT; data bus held at zero otherwise
  always_comb begin
    fifo_we   = 1'b0;
    fifo_data = '0;
    busy      = 1'b0;
    if (state_reg == ST_GRANT) begin
      busy    = 1'b1;
      fifo_we = word_ok;
      if (word_ok) begin
        fifo_data = req_words[last_idx_reg];
      end
    end
  end

  assign grant = grant_reg;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single FIFO write port (data_in/we, honouring fifo_full) between NUM_REQ independent producers.
- Sits between the producers and the FIFO top level, and drives the FIFO's we and data_in directly.
- Grants are burst-based: a granted producer keeps the port for up to MAX_BURST accepted words, then the grant rotates.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- WIDTH, 16, data word width; must equal the FIFO width.
- MAX_BURST, 4, maximum words accepted per grant (>=1).
- IDX_W, $clog2(NUM_REQ), width of the grant index.
- CNT_W, $clog2(MAX_BURST+1), width of the burst counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-producer "word available"; held until acked or withdrawn.
- req_data  in  NUM_REQ*WIDTH  producer words; producer i occupies bits [i*WIDTH +: WIDTH].
- fifo_full  in  1  FIFO full flag.
- fifo_we  out  1  FIFO write enable.
- fifo_data  out  WIDTH  FIFO write data.
- ack  out  NUM_REQ  one-hot, one cycle per accepted word; the producer advances its word on ack.
- grant  out  NUM_REQ  one-hot registered grant; all zero when idle.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, grant=0, burst_cnt=0, last_idx=NUM_REQ-1, so producer 0 wins first.
  - Outputs are zero while reset is asserted: fifo_we=0, ack=0, fifo_data=0, busy=0.
  - Reset asserted mid-burst aborts the burst; no partial write occurs in that cycle.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching last_idx+1, last_idx+2, ... with wrap modulo NUM_REQ.
  - Next cycle: grant=onehot(pick), last_idx=pick, burst_cnt=0, state=GRANT.
  - If req == 0, stay in IDLE.
  - No writes occur in IDLE.
- GRANT, with g the granted index:
  - fifo_we = req[g] & ~fifo_full (combinational from the registered grant).
  - ack[g] = fifo_we; fifo_data = req_data[g]; all other ack bits 0.
  - Each accepted word increments burst_cnt.
  - Exit to IDLE next cycle when either:
    - the accepted word makes burst_cnt reach MAX_BURST; or
    - req[g]=0, i.e. the producer withdrew or finished.
  - Otherwise stay in GRANT.
- Every exit passes through IDLE: one bubble cycle between grants, so the maximum port utilisation is MAX_BURST/(MAX_BURST+1).
- fifo_full high in GRANT: no write, no ack, burst_cnt holds, grant holds indefinitely (no timeout). Dropping req while stalled releases the grant.
- fifo_full is sampled in the same cycle, with no registered lag. The FIFO must therefore present full combinationally valid before the edge.
- Fairness:
  - After granting index g, g has the lowest priority at the next arbitration.
  - With all producers requesting continuously, grants cycle 0,1,...,NUM_REQ-1,0,...
- fifo_data is 0 whenever fifo_we=0, to keep the bus quiet for debug.
- Requests from non-granted producers are ignored; their ack stays 0.
- A producer must not change req_data[i] while req[i]=1 and ack[i]=0.

Decomposition:
- Shared constants header: state encodings (ST_IDLE=1'b0, ST_GRANT=1'b1). The FIFO and arbiter WIDTH defaults also live there so they stay aligned.
- One combinational sub-module, rr_pick:
  - Inputs: req, last_idx.
  - Outputs: pick_idx, pick_valid.
  - Rotate-and-priority-encode; reusable by a future read-side scheduler.
- The FSM, burst counter and data mux stay in fifo_wr_arbiter.

Test Plan:
- Reset/first grant:
  - Stimulus: rst low, then high; req=4'b1111, fifo_full=0.
  - Response: first grant=4'b0001 one cycle after reset release; 4 acks to producer 0; then one idle cycle; then grant=4'b0010.
- Rotation:
  - Stimulus: req=4'b1010 held, MAX_BURST=4.
  - Response: grant sequence 1,3,1,3; each grant yields exactly 4 fifo_we pulses; fifo_data matches the granted producer's words.
- Early release:
  - Stimulus: producer 2 alone raises req for 2 words, then drops it.
  - Response: 2 acks, exit to IDLE, burst_cnt back to 0; the next lone request from 2 is granted again.
- Full stall:
  - Stimulus: fifo_full=1 for 5 cycles mid-burst after 2 words.
  - Response: fifo_we=0 and ack=0 for those 5 cycles, grant unchanged; after full drops, exactly 2 more words are written, then the grant rotates.
- Async reset mid-burst:
  - Stimulus: rst low between clock edges during a GRANT.
  - Response: grant, fifo_we and ack go 0 immediately; after release, arbitration restarts with priority at producer 0.
- Withdraw while stalled:
  - Stimulus: fifo_full=1, granted producer drops req.
  - Response: IDLE next cycle, with no write and no ack for that producer.
